// File: rtl/sdram_frame_fetcher.sv
// rtl/sdram_frame_fetcher.sv - reads one packed RGB frame from SDRAM and unpacks it into the input image buffer
//
// Ports:
//   sys_clk, reset_n          clock, asynchronous active-low reset
//   start                     one-cycle request to fetch a frame (ignored unless idle)
//   mem_rd_req/addr/gnt       SDRAM read request, word address, same-cycle grant
//   mem_rd_valid/data         SDRAM read data return
//   pixel_we/addr/data        byte writes into the input image buffer
//   busy, done, error         frame in progress, one-cycle completion pulse, sticky timeout flag

module sdram_frame_fetcher #(
    parameter int          IMAGE_WIDTH  = 224,
    parameter int          IMAGE_HEIGHT = 224,
    parameter int          CHANNELS     = 3,
    parameter logic [19:0] BASE_ADDR    = 20'h00000,
    parameter int          TIMEOUT      = 1023
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        mem_rd_req,
    output logic [19:0] mem_rd_addr,
    input  logic        mem_rd_gnt,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        pixel_we,
    output logic [19:0] pixel_addr,
    output logic [7:0]  pixel_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int TOTAL_BYTES = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNELS;
    localparam int NUM_WORDS   = (TOTAL_BYTES + 3) / 4;
    localparam int TAIL_BYTES  = TOTAL_BYTES % 4;
    // The counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT is the error itself.
    localparam int TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0] TMO_LAST        = TW'(TIMEOUT - 1);
    localparam logic [19:0]   LAST_WORD       = 20'(NUM_WORDS - 1);
    localparam logic [2:0]    LAST_WORD_BYTES = (TAIL_BYTES == 0) ? 3'd4 : 3'(TAIL_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UNPACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [19:0]   word_cnt;
    logic [19:0]   byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   word_buf;
    logic [2:0]    byte_idx;    // next byte of word_buf to write; byte 0 goes out on the valid edge
    logic [2:0]    word_bytes;

    // Only the final word may be short, so the buffer never sees an address >= TOTAL_BYTES.
    assign word_bytes = (word_cnt == LAST_WORD) ? LAST_WORD_BYTES : 3'd4;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            word_cnt    <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            word_buf    <= '0;
            byte_idx    <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            pixel_we    <= 1'b0;
            pixel_addr  <= '0;
            pixel_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_cnt    <= '0;
                        byte_cnt    <= '0;
                        tmo_cnt     <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        mem_rd_req  <= 1'b1;
                        mem_rd_addr <= BASE_ADDR;
                        state       <= S_REQ;
                    end
                end

                // A valid arriving together with the grant belongs to no request yet and is dropped.
                S_REQ: begin
                    if (mem_rd_gnt) begin
                        mem_rd_req <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= S_WAIT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_rd_req <= 1'b0;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                        state      <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_WAIT: begin
                    if (mem_rd_valid) begin
                        word_buf   <= mem_rd_data;
                        pixel_we   <= 1'b1;
                        pixel_addr <= byte_cnt;
                        pixel_data <= mem_rd_data[7:0];
                        byte_cnt   <= byte_cnt + 20'd1;
                        byte_idx   <= 3'd1;
                        state      <= S_UNPACK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_UNPACK: begin
                    if (byte_idx < word_bytes) begin
                        pixel_we   <= 1'b1;
                        pixel_addr <= byte_cnt;
                        pixel_data <= word_buf[{byte_idx[1:0], 3'b000} +: 8];
                        byte_cnt   <= byte_cnt + 20'd1;
                        byte_idx   <= byte_idx + 3'd1;
                    end else begin
                        pixel_we <= 1'b0;
                        word_cnt <= word_cnt + 20'd1;
                        if (word_cnt == LAST_WORD) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= BASE_ADDR + word_cnt + 20'd1;
                            tmo_cnt     <= '0;
                            state       <= S_REQ;
                        end
                    end
                end

                S_DONE:  state <= S_IDLE;
                S_ERROR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_fetcher.sv
// tb/tb_sdram_frame_fetcher.sv - scoreboard bench for sdram_frame_fetcher

module tb_sdram_frame_fetcher;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        mem_rd_gnt = 1'b0;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = '0;

    logic        a_mem_rd_req, a_pixel_we, a_busy, a_done, a_error;
    logic [19:0] a_mem_rd_addr, a_pixel_addr;
    logic [7:0]  a_pixel_data;
    logic        b_mem_rd_req, b_pixel_we, b_busy, b_done, b_error;
    logic [19:0] b_mem_rd_addr, b_pixel_addr;
    logic [7:0]  b_pixel_data;

    logic [52:0] a_outs, b_outs;
    assign a_outs = {a_mem_rd_req, a_mem_rd_addr, a_pixel_we, a_pixel_addr, a_pixel_data, a_busy, a_done, a_error};
    assign b_outs = {b_mem_rd_req, b_mem_rd_addr, b_pixel_we, b_pixel_addr, b_pixel_data, b_busy, b_done, b_error};

    // 2x2x3 frame: 12 bytes in 3 full words
    sdram_frame_fetcher #(
        .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNELS(3), .BASE_ADDR(20'h00100), .TIMEOUT(15)
    ) dut_a (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start_a),
        .mem_rd_req(a_mem_rd_req), .mem_rd_addr(a_mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .pixel_we(a_pixel_we), .pixel_addr(a_pixel_addr), .pixel_data(a_pixel_data),
        .busy(a_busy), .done(a_done), .error(a_error)
    );

    // 1x1x3 frame: a single word of which only 3 bytes are used
    sdram_frame_fetcher #(
        .IMAGE_WIDTH(1), .IMAGE_HEIGHT(1), .CHANNELS(3), .BASE_ADDR(20'h00100), .TIMEOUT(15)
    ) dut_b (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start_b),
        .mem_rd_req(b_mem_rd_req), .mem_rd_addr(b_mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .pixel_we(b_pixel_we), .pixel_addr(b_pixel_addr), .pixel_data(b_pixel_data),
        .busy(b_busy), .done(b_done), .error(b_error)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass = 0;

    logic [27:0] exp_wr[$];
    logic [27:0] obs_wr[$];
    logic [19:0] exp_req[$];
    logic [19:0] obs_req[$];
    int          done_seen = 0;

    // Observation side of the scoreboard: buffer writes, granted request addresses, done pulses.
    always @(negedge sys_clk) begin
        if (a_pixel_we) obs_wr.push_back({a_pixel_addr, a_pixel_data});
        if (b_pixel_we) obs_wr.push_back({b_pixel_addr, b_pixel_data});
        if (a_mem_rd_req && mem_rd_gnt) obs_req.push_back(a_mem_rd_addr);
        if (b_mem_rd_req && mem_rd_gnt) obs_req.push_back(b_mem_rd_addr);
        if (a_done || b_done) done_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] frame_word(input int w);
        return {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
    endfunction

    task automatic push_word(input int w);
        exp_req.push_back(20'h00100 + 20'(w));
        for (int k = 0; k < 4; k++) exp_wr.push_back({20'(4 * w + k), 8'(4 * w + k)});
    endtask

    // SDRAM responder for one word: wait for a request, optionally stall, grant, return data lat cycles later.
    task automatic serve_word(input bit sel, input int stall, input int lat, input logic [31:0] data, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((sel ? b_mem_rd_req : a_mem_rd_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) begin
            repeat (stall) step();
            mem_rd_gnt = 1'b1;
            step();
            mem_rd_gnt = 1'b0;
            repeat (lat - 1) step();
            mem_rd_valid = 1'b1;
            mem_rd_data  = data;
            step();
            mem_rd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        n_checks++; if (a_outs !== '0) $display("FAIL reset_a: outputs %h, expected 0", a_outs); else n_pass++;
        n_checks++; if (b_outs !== '0) $display("FAIL reset_b: outputs %h, expected 0", b_outs); else n_pass++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_frame();
        bit ok;
        logic [19:0] e20, o20;
        logic [27:0] e28, o28;
        obs_wr.delete(); obs_req.delete(); exp_wr.delete(); exp_req.delete();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_checks++;
        if ({a_mem_rd_req, a_mem_rd_addr, a_busy} !== {1'b1, 20'h00100, 1'b1})
            $display("FAIL basic_latency: req/addr/busy %b/%h/%b, expected 1/00100/1", a_mem_rd_req, a_mem_rd_addr, a_busy);
        else n_pass++;
        for (int w = 0; w < 3; w++) begin
            push_word(w);
            serve_word(1'b0, 0, 2, frame_word(w), ok);
            n_checks++; if (!ok) $display("FAIL basic_serve: no request for word %0d", w); else n_pass++;
        end
        for (int i = 0; i < 100 && a_done !== 1'b1; i++) step();
        n_checks++; if (a_done !== 1'b1) $display("FAIL basic_done: done %b, expected 1", a_done); else n_pass++;
        // start coinciding with the done pulse must be ignored
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_checks++;
        if ({a_busy, a_mem_rd_req} !== 2'b00) $display("FAIL basic_start_at_done: busy/req %b%b, expected 00", a_busy, a_mem_rd_req);
        else n_pass++;
        step();
        n_checks++; if (done_seen !== 1) $display("FAIL basic_done_count: %0d pulses, expected 1", done_seen); else n_pass++;
        n_checks++; if (a_error !== 1'b0) $display("FAIL basic_error: error %b, expected 0", a_error); else n_pass++;
        while (exp_req.size() > 0) begin
            e20 = exp_req.pop_front();
            n_checks++;
            if (obs_req.size() == 0) $display("FAIL basic_req: observation queue empty, expected %h", e20);
            else begin
                o20 = obs_req.pop_front();
                if (o20 !== e20) $display("FAIL basic_req: got %h, expected %h", o20, e20); else n_pass++;
            end
        end
        while (exp_wr.size() > 0) begin
            e28 = exp_wr.pop_front();
            n_checks++;
            if (obs_wr.size() == 0) $display("FAIL basic_wr: observation queue empty, expected addr/data %h", e28);
            else begin
                o28 = obs_wr.pop_front();
                if (o28 !== e28) $display("FAIL basic_wr: got addr/data %h, expected %h", o28, e28); else n_pass++;
            end
        end
        n_checks++; if (obs_wr.size() != 0) $display("FAIL basic_extra_wr: %0d extra writes, expected 0", obs_wr.size()); else n_pass++;
    endtask

    task automatic test_partial_word();
        int d0;
        logic [27:0] e28, o28;
        obs_wr.delete(); obs_req.delete(); exp_wr.delete();
        d0 = done_seen;
        exp_wr.push_back({20'd0, 8'hAA});
        exp_wr.push_back({20'd1, 8'hBB});
        exp_wr.push_back({20'd2, 8'hCC});
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        n_checks++;
        if ({b_mem_rd_req, b_mem_rd_addr} !== {1'b1, 20'h00100}) $display("FAIL partial_req: req/addr %b/%h, expected 1/00100", b_mem_rd_req, b_mem_rd_addr);
        else n_pass++;
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data = 32'hDDCCBBAA;
        step();
        mem_rd_valid = 1'b0;
        n_checks++;
        if ({b_pixel_we, b_pixel_addr, b_pixel_data} !== {1'b1, 20'd0, 8'hAA})
            $display("FAIL partial_first_write: we/addr/data %b/%h/%h, expected 1/00000/aa", b_pixel_we, b_pixel_addr, b_pixel_data);
        else n_pass++;
        for (int i = 0; i < 50 && b_done !== 1'b1; i++) step();
        n_checks++; if (b_done !== 1'b1) $display("FAIL partial_done: done %b, expected 1", b_done); else n_pass++;
        step();
        n_checks++; if (done_seen - d0 !== 1) $display("FAIL partial_done_count: %0d pulses, expected 1", done_seen - d0); else n_pass++;
        while (exp_wr.size() > 0) begin
            e28 = exp_wr.pop_front();
            n_checks++;
            if (obs_wr.size() == 0) $display("FAIL partial_wr: observation queue empty, expected addr/data %h", e28);
            else begin
                o28 = obs_wr.pop_front();
                if (o28 !== e28) $display("FAIL partial_wr: got addr/data %h, expected %h", o28, e28); else n_pass++;
            end
        end
        n_checks++; if (obs_wr.size() != 0) $display("FAIL partial_extra_wr: %0d extra writes (byte DD must not be written)", obs_wr.size()); else n_pass++;
    endtask

    task automatic test_grant_stall();
        bit ok;
        int stable;
        logic [19:0] e20, o20;
        logic [27:0] e28, o28;
        obs_wr.delete(); obs_req.delete(); exp_wr.delete(); exp_req.delete();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_mem_rd_req === 1'b1 && a_mem_rd_addr === 20'h00100) stable++;
            step();
        end
        n_checks++; if (stable !== 5) $display("FAIL stall_stable: %0d stable cycles, expected 5", stable); else n_pass++;
        n_checks++; if (obs_wr.size() != 0) $display("FAIL stall_no_write: %0d writes, expected 0", obs_wr.size()); else n_pass++;
        for (int w = 0; w < 3; w++) begin
            push_word(w);
            serve_word(1'b0, 0, 2, frame_word(w), ok);
            n_checks++; if (!ok) $display("FAIL stall_serve: no request for word %0d", w); else n_pass++;
        end
        for (int i = 0; i < 100 && a_done !== 1'b1; i++) step();
        n_checks++; if (a_done !== 1'b1) $display("FAIL stall_done: done %b, expected 1", a_done); else n_pass++;
        step();
        while (exp_req.size() > 0) begin
            e20 = exp_req.pop_front();
            n_checks++;
            if (obs_req.size() == 0) $display("FAIL stall_req: observation queue empty, expected %h", e20);
            else begin
                o20 = obs_req.pop_front();
                if (o20 !== e20) $display("FAIL stall_req: got %h, expected %h", o20, e20); else n_pass++;
            end
        end
        while (exp_wr.size() > 0) begin
            e28 = exp_wr.pop_front();
            n_checks++;
            if (obs_wr.size() == 0) $display("FAIL stall_wr: observation queue empty, expected addr/data %h", e28);
            else begin
                o28 = obs_wr.pop_front();
                if (o28 !== e28) $display("FAIL stall_wr: got addr/data %h, expected %h", o28, e28); else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n, d0;
        obs_wr.delete(); obs_req.delete();
        d0 = done_seen;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        n = 0;
        while (a_error !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_checks++; if (n !== 15) $display("FAIL timeout_cycles: error after %0d wait cycles, expected 15", n); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL timeout_busy: busy %b, expected 0", a_busy); else n_pass++;
        repeat (3) step();
        n_checks++; if (a_error !== 1'b1) $display("FAIL timeout_sticky: error %b, expected 1", a_error); else n_pass++;
        n_checks++; if (a_mem_rd_req !== 1'b0) $display("FAIL timeout_no_req: req %b, expected 0", a_mem_rd_req); else n_pass++;
        n_checks++; if (done_seen - d0 !== 0 || obs_wr.size() != 0)
            $display("FAIL timeout_quiet: %0d done pulses and %0d writes, expected 0 and 0", done_seen - d0, obs_wr.size());
        else n_pass++;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_checks++;
        if ({a_error, a_busy, a_mem_rd_addr} !== {1'b0, 1'b1, 20'h00100})
            $display("FAIL timeout_restart: error/busy/addr %b/%b/%h, expected 0/1/00100", a_error, a_busy, a_mem_rd_addr);
        else n_pass++;
        for (int w = 0; w < 3; w++) serve_word(1'b0, 0, 2, frame_word(w), ok);
        for (int i = 0; i < 100 && a_done !== 1'b1; i++) step();
        n_checks++; if (a_done !== 1'b1) $display("FAIL timeout_recover_done: done %b, expected 1", a_done); else n_pass++;
        step();
        n_checks++; if (obs_wr.size() != 12) $display("FAIL timeout_recover_writes: %0d writes, expected 12", obs_wr.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [19:0] e20, o20;
        logic [27:0] e28, o28;
        obs_wr.delete(); obs_req.delete(); exp_wr.delete(); exp_req.delete();
        start_a = 1'b1;
        step();
        // second start while busy plus a spurious valid while still requesting
        start_a = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data = 32'hEEEEEEEE;
        step();
        start_a = 1'b0;
        mem_rd_valid = 1'b0;
        n_checks++;
        if ({a_mem_rd_req, a_mem_rd_addr, a_busy, a_pixel_we} !== {1'b1, 20'h00100, 1'b1, 1'b0})
            $display("FAIL busy_start_ignored: req/addr/busy/we %b/%h/%b/%b, expected 1/00100/1/0", a_mem_rd_req, a_mem_rd_addr, a_busy, a_pixel_we);
        else n_pass++;
        push_word(0);
        mem_rd_gnt = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data = 32'hDEADBEEF;
        step();
        mem_rd_valid = 1'b0;
        n_checks++;
        if ({a_mem_rd_req, a_pixel_we} !== 2'b00) $display("FAIL gnt_valid_same_cycle: req/we %b%b, expected 00", a_mem_rd_req, a_pixel_we);
        else n_pass++;
        // grant held while no request is pending is meaningless; real data follows
        mem_rd_valid = 1'b1;
        mem_rd_data = frame_word(0);
        step();
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b0;
        for (int w = 1; w < 3; w++) begin
            push_word(w);
            serve_word(1'b0, 0, 1, frame_word(w), ok);
            n_checks++; if (!ok) $display("FAIL busy_serve: no request for word %0d", w); else n_pass++;
        end
        for (int i = 0; i < 100 && a_done !== 1'b1; i++) step();
        n_checks++; if (a_done !== 1'b1) $display("FAIL busy_done: done %b, expected 1", a_done); else n_pass++;
        step();
        while (exp_req.size() > 0) begin
            e20 = exp_req.pop_front();
            n_checks++;
            if (obs_req.size() == 0) $display("FAIL busy_req: observation queue empty, expected %h", e20);
            else begin
                o20 = obs_req.pop_front();
                if (o20 !== e20) $display("FAIL busy_req: got %h, expected %h", o20, e20); else n_pass++;
            end
        end
        while (exp_wr.size() > 0) begin
            e28 = exp_wr.pop_front();
            n_checks++;
            if (obs_wr.size() == 0) $display("FAIL busy_wr: observation queue empty, expected addr/data %h", e28);
            else begin
                o28 = obs_wr.pop_front();
                if (o28 !== e28) $display("FAIL busy_wr: got addr/data %h, expected %h", o28, e28); else n_pass++;
            end
        end
        n_checks++; if (obs_wr.size() != 0) $display("FAIL busy_extra_wr: %0d extra writes, expected 0", obs_wr.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int d0;
        logic [27:0] e28, o28;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        serve_word(1'b0, 0, 2, frame_word(0), ok);
        for (int i = 0; i < 50 && a_mem_rd_req !== 1'b1; i++) step();
        mem_rd_gnt = 1'b1;
        step();
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data = frame_word(1);
        step();
        mem_rd_valid = 1'b0;
        step();
        n_checks++; if (a_pixel_we !== 1'b1) $display("FAIL midreset_in_unpack: we %b, expected 1", a_pixel_we); else n_pass++;
        d0 = done_seen;
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (a_outs !== '0) $display("FAIL midreset_async: outputs %h, expected 0", a_outs); else n_pass++;
        #2 reset_n = 1'b1;
        step();
        n_checks++; if (a_outs !== '0 || done_seen != d0) $display("FAIL midreset_idle: outputs %h done pulses %0d, expected 0 and 0", a_outs, done_seen - d0); else n_pass++;
        obs_wr.delete(); obs_req.delete(); exp_wr.delete(); exp_req.delete();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_checks++;
        if ({a_mem_rd_req, a_mem_rd_addr} !== {1'b1, 20'h00100}) $display("FAIL midreset_restart: req/addr %b/%h, expected 1/00100", a_mem_rd_req, a_mem_rd_addr);
        else n_pass++;
        for (int w = 0; w < 3; w++) begin
            push_word(w);
            serve_word(1'b0, 0, 2, frame_word(w), ok);
        end
        for (int i = 0; i < 100 && a_done !== 1'b1; i++) step();
        n_checks++; if (a_done !== 1'b1) $display("FAIL midreset_done: done %b, expected 1", a_done); else n_pass++;
        step();
        while (exp_wr.size() > 0) begin
            e28 = exp_wr.pop_front();
            n_checks++;
            if (obs_wr.size() == 0) $display("FAIL midreset_wr: observation queue empty, expected addr/data %h", e28);
            else begin
                o28 = obs_wr.pop_front();
                if (o28 !== e28) $display("FAIL midreset_wr: got addr/data %h, expected %h", o28, e28); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_partial_word();
        test_grant_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_frame_fetcher.md
Name: sdram_frame_fetcher

Overview:
- Upstream input stage of the segmentation pipeline.
- On a start pulse, reads one packed RGB frame from SDRAM as 32-bit words through the SDRAM controller's read port.
- Unpacks each word into bytes and writes them one per cycle into the input image buffer (byte address, byte data, write enable).
- Signals completion to the top-level state machine, or flags a read timeout.

Parameters:
- IMAGE_WIDTH, 224, pixels per row.
- IMAGE_HEIGHT, 224, rows per frame.
- CHANNELS, 3, bytes per pixel.
- BASE_ADDR, 20'h00000, SDRAM word address of first frame word.
- TIMEOUT, 1023, maximum cycles spent waiting for a grant or for read data before error.
- Derived: TOTAL_BYTES = IMAGE_WIDTH*IMAGE_HEIGHT*CHANNELS (150528 at defaults); NUM_WORDS = ceil(TOTAL_BYTES/4) (37632).

Ports:
- sys_clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to fetch a frame
- mem_rd_req  out  1  read request to SDRAM controller
- mem_rd_addr  out  20  word address of request
- mem_rd_gnt  in  1  controller accepted request (same cycle as req)
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  32  read data word
- pixel_we  out  1  buffer write enable
- pixel_addr  out  20  buffer byte address
- pixel_data  out  8  buffer write byte
- busy  out  1  high from accepted start until DONE/ERROR
- done  out  1  one-cycle pulse, frame fully written
- error  out  1  sticky timeout flag

Behaviour:
- Reset values (asynchronous, reset_n=0), all outputs 0:
  - mem_rd_req, mem_rd_addr, pixel_we, pixel_addr, pixel_data, busy, done, error.
  - State IDLE; word counter, byte counter and timeout counter all 0.
- Reset is asynchronous, active-low; clock is sys_clk.
- States: IDLE, REQ, WAIT, UNPACK, DONE, ERROR.
- IDLE:
  - start=1 → REQ; clear word/byte counters and error; busy=1 next cycle.
  - start=0 → stay.
- REQ:
  - mem_rd_req=1 with mem_rd_addr = BASE_ADDR + word_cnt, both held stable until mem_rd_gnt=1.
  - On grant: req drops next cycle; go to WAIT; timeout counter cleared.
- WAIT:
  - mem_rd_valid=1 → latch mem_rd_data, go to UNPACK.
  - Timeout counter increments each cycle in REQ or WAIT. Reaching TIMEOUT → ERROR.
- UNPACK:
  - Writes up to 4 bytes, one per cycle, little-endian: byte k = data[8k+7:8k].
  - Each write: pixel_we=1, pixel_addr = byte_cnt, pixel_data = byte; byte_cnt increments after each write.
  - Final word writes only TOTAL_BYTES mod 4 bytes when that value is non-zero; no write ever reaches address ≥ TOTAL_BYTES.
  - After the last byte of a word: word_cnt increments; go to DONE if word_cnt was NUM_WORDS-1, else REQ.
- DONE: done=1 for exactly one cycle, busy deasserts the same cycle, → IDLE.
- ERROR:
  - error=1, busy=0, no further requests or writes → IDLE.
  - error stays high until the next accepted start.
- Latency: a start in cycle 0 gives mem_rd_req=1 in cycle 1. A valid in cycle t gives the first pixel_we in cycle t+1.
- Only one read is outstanding at a time. Throughput ≤ 1 byte/cycle.
- Boundary conditions:
  - start while busy → ignored, no restart.
  - mem_rd_valid outside WAIT → ignored.
  - mem_rd_gnt while req=0 → ignored.
  - gnt and valid in the same cycle while in REQ → valid ignored; a valid is expected after the grant.
  - reset_n low mid-frame → immediate return to IDLE: pixel_we=0 and mem_rd_req=0 asynchronously; no done pulse; partial buffer contents undefined.
  - start in the same cycle as done → ignored (block not yet IDLE).
- Arithmetic: mem_rd_addr wraps modulo 2^20. pixel_addr is 20 bits, sufficient for TOTAL_BYTES ≤ 1,048,575; larger configurations are illegal.

Test Plan:
- Basic frame: W=2,H=2,C=3 (12 bytes, 3 words), BASE_ADDR=0x100, words 0x03020100, 0x07060504, 0x0B0A0908, valid 2 cycles after each gnt → requests at 0x100..0x102; 12 writes with addr i, data i; one done pulse; error=0.
- Partial last word: W=1,H=1,C=3, word 0xDDCCBBAA → exactly 3 writes (AA, BB, CC at addr 0..2); byte DD is never written; done pulses.
- Grant stall: hold mem_rd_gnt=0 for 5 cycles → mem_rd_req and mem_rd_addr stay stable all 5 cycles; no writes; completes normally after the grant.
- Timeout: TIMEOUT=15, grant given, valid never returned → error=1 and busy=0 after 15 WAIT cycles; no done; next start clears error.
- Start while busy and a spurious valid in REQ → no restart; spurious data not written; addresses unchanged.
- Reset mid-frame: reset_n=0 during UNPACK of word 1 → outputs 0 immediately; after release a new start fetches from BASE_ADDR and writes from addr 0.
